// File: rtl/hazard_sequencer.sv
// hazard_sequencer: pipeline stall/flush controller resolving memory wait, branch and load-use events,
// with a memory-wait timeout watchdog and a saturating stall-cycle counter.
module hazard_sequencer #(
    parameter int REG_W    = 5,
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] rs1_d,
    input  logic [REG_W-1:0] rs2_d,
    input  logic [REG_W-1:0] rd_e,
    input  logic             load_e,
    input  logic             pc_src_e,
    input  logic             dmem_req_m,
    input  logic             dmem_ack,
    input  logic             clr_cnt,
    output logic             en_f,
    output logic             en_d,
    output logic             en_e,
    output logic             en_m,
    output logic             en_w,
    output logic             flush_d,
    output logic             flush_e,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;
    state_t           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             mem_timeout_q, mem_timeout_d;
    logic             memhold, loaduse, hold_all, flush_br, bubble;

    assign memhold  = dmem_req_m & ~dmem_ack;
    assign loaduse  = load_e & (rd_e != '0) & ((rd_e == rs1_d) | (rd_e == rs2_d));
    assign hold_all = (state_q == ERROR) | memhold;
    assign flush_br = ~hold_all & pc_src_e;
    assign bubble   = ~hold_all & ~pc_src_e & loaduse;

    // Held reset forces every register closed and both bubbles injected.
    assign en_f    = reset & ~hold_all & ~bubble;
    assign en_d    = reset & ~hold_all & ~bubble;
    assign en_e    = reset & ~hold_all;
    assign en_m    = reset & ~hold_all;
    assign en_w    = reset & ~hold_all;
    assign flush_d = ~reset | flush_br;
    assign flush_e = ~reset | flush_br | bubble;

    assign mem_timeout = mem_timeout_q;
    assign stall_cnt   = stall_cnt_q;

    always_comb begin
        state_d       = (state_q == ERROR) ? ERROR :
                        ~memhold ? RUN :
                        (wait_cnt_q == 8'(WAIT_MAX - 1)) ? ERROR : MEM_WAIT;
        wait_cnt_d    = (memhold && state_q != ERROR) ? wait_cnt_q + 8'd1 : 8'd0;
        mem_timeout_d = mem_timeout_q | (state_d == ERROR);
        stall_cnt_d   = clr_cnt ? '0 :
                        (~en_f & ~&stall_cnt_q) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= RUN;
            wait_cnt_q    <= 8'd0;
            stall_cnt_q   <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end
endmodule
